mipsctl_fsm: RTL and testbench
==============================

Name: mipsctl_fsm

Overview:
- Multicycle main control FSM; sits directly upstream of the ALU-control decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives all datapath enables and muxes, plus the 3-bit aluop consumed by the ALU-control decoder.
- Stretches memory states while the unified instruction/data memory deasserts memready.

Parameters:
- none (opcode and state encodings are fixed by this spec)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; forces FETCH
- op  in  6  opcode field of the instruction register
- memready  in  1  memory access completes this cycle
- pcwrite  out  1  unconditional PC write
- branch  out  1  PC write if ALU zero
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regdst  out  1  0=rt, 1=rd
- memtoreg  out  1  0=ALUOut, 1=memory data
- regwrite  out  1  register file write
- alusrca  out  1  0=PC, 1=A
- alusrcb  out  2  00=B, 01=constant 4, 10=sign-extended immediate, 11=sign-extended immediate shifted left 2
- pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
- aluop  out  3  000 add, 001 sub, 010 R-type (use funct), 011 and, 100 or, 101 slt, 110 dadd
- state  out  4  current state, for debug and verification
- illegal  out  1  illegal-opcode trap flag (see Optional Feature)

Behaviour:
- One registered 4-bit state; all outputs decoded combinationally from state only, with one exception: FETCH also uses memready.
- Every output is 0 in any state that does not name it.
- Reset (asynchronous, any time, including mid-instruction): state=FETCH(0) immediately.
  - Outputs take the FETCH decode: alusrcb=01, everything else 0 unless memready=1.
- States, their encodings and asserted outputs:
  - FETCH 0: iord=0, alusrca=0, alusrcb=01, aluop=000; irwrite=pcwrite=memready.
  - DECODE 1: alusrcb=11, aluop=000.
  - MEMADR 2: alusrca=1, alusrcb=10, aluop=000.
  - MEMRD 3: iord=1.
  - MEMWB 4: memtoreg=1, regwrite=1.
  - MEMWR 5: iord=1, memwrite=1.
  - RTYPEEX 6: alusrca=1, alusrcb=00, aluop=010.
  - RTYPEWB 7: regdst=1, regwrite=1.
  - BEQEX 8: alusrca=1, alusrcb=00, aluop=001, pcsrc=01, branch=1.
  - IEXE 9: alusrca=1, alusrcb=10; aluop by op: ADDI 000, ANDI 011, ORI 100, SLTI 101, DADDI 110.
  - IWB 10: regwrite=1.
  - JEX 11: pcsrc=10, pcwrite=1.
- Transitions:
  - FETCH->DECODE when memready, else stay.
  - DECODE by op:
    - LW 100011 / SW 101011 -> MEMADR
    - 000000 -> RTYPEEX
    - BEQ 000100 -> BEQEX
    - ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010, DADDI 011000 -> IEXE
    - J 000010 -> JEX
    - other -> illegal handling (Optional Feature)
  - MEMADR -> MEMRD if op=LW, MEMWR if op=SW.
  - MEMRD -> MEMWB when memready, else stay.
  - MEMWR -> FETCH when memready, else stay; memwrite held high while waiting.
  - RTYPEEX->RTYPEWB; IEXE->IWB.
  - MEMWB, RTYPEWB, IWB, BEQEX, JEX -> FETCH.
- Latency with memready tied 1: LW 5 cycles, SW 4, R-type 4, I-type 4, BEQ 3, J 3.
  - Each memready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- op is sampled every cycle; the IR is stable after FETCH, so no internal op latch.
- Unreachable state codes 12..15 (when not used) -> FETCH next cycle, outputs 0.

Optional Feature:
- Macro: MIPSCTL_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE -> TRAP state 12.
  - All outputs 0, illegal=1; stays in TRAP until reset.
- Undefined: an unknown opcode in DECODE -> FETCH (treated as 2-cycle NOP).
  - illegal tied 0; state 12 unreachable.

Test Plan:
- Reset mid-RTYPEEX (op=000000, memready=1) -> state=0 same cycle; next edge state=1; alusrcb=01, pcwrite=irwrite=1.
- LW (op=100011), memready=1 -> states 0,1,2,3,4,0; MEMWB has memtoreg=1, regwrite=1, regdst=0.
- SW (op=101011), memready low 2 cycles in MEMWR -> state 5 held 3 cycles with memwrite=1 throughout, then state 0.
- DADDI (op=011000) -> IEXE with aluop=110, alusrcb=10, alusrca=1; then IWB with regwrite=1.
- BEQ (op=000100) -> BEQEX with aluop=001, branch=1, pcsrc=01; J (op=000010) -> JEX with pcsrc=10, pcwrite=1; both return to 0 after 3 cycles.
- op=111111 -> with MIPSCTL_ILLEGAL_TRAP_EN: state=12, illegal=1 held 10 cycles until reset; without: state 1->0, illegal=0.

Source files
------------

// File: rtl/mipsctl_fsm.sv
// Multicycle MIPS main control FSM driving datapath enables, muxes and aluop.
// Define MIPSCTL_ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky state 12.
module mipsctl_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       pcwrite,
  output logic       branch,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop,
  output logic [3:0] state,
  output logic       illegal
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_IEXE    = 4'd9;
  localparam logic [3:0] S_IWB     = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;
`ifdef MIPSCTL_ILLEGAL_TRAP_EN
  localparam logic [3:0] S_TRAP    = 4'd12;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_DADDI = 6'b011000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [3:0] state_q;
  logic [3:0] state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = memready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI, OP_ANDI, OP_ORI,
          OP_SLTI, OP_DADDI:
                        state_d = S_IEXE;
          OP_J:         state_d = S_JEX;
`ifdef MIPSCTL_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      // IR is stable here, so a non-LW/SW op can only mean corruption
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:   state_d = memready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   state_d = memready ? S_FETCH : S_MEMWR;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_IEXE:    state_d = S_IWB;
`ifdef MIPSCTL_ILLEGAL_TRAP_EN
      S_TRAP:    state_d = S_TRAP;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = 3'b000;
    illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = memready;
        pcwrite = memready;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = 3'b010;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = 3'b001;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_IEXE: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op)
          OP_ANDI:  aluop = 3'b011;
          OP_ORI:   aluop = 3'b100;
          OP_SLTI:  aluop = 3'b101;
          OP_DADDI: aluop = 3'b110;
          default:  aluop = 3'b000;
        endcase
      end
      S_IWB:     regwrite = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
`ifdef MIPSCTL_ILLEGAL_TRAP_EN
      S_TRAP:    illegal = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mipsctl_fsm.sv
// Bench for mipsctl_fsm: fixed vector table, corner sequences, then random
// instruction streams checked against a per-instruction state-plan model.
module tb_mipsctl_fsm;

  logic       clk, reset, memready;
  logic [5:0] op;
  logic       pcwrite, branch, iord, memwrite, irwrite, regdst;
  logic       memtoreg, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;
  logic [3:0] state;

  mipsctl_fsm dut (
    .clk(clk), .reset(reset), .op(op), .memready(memready),
    .pcwrite(pcwrite), .branch(branch), .iord(iord),
    .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .state(state), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] J = 6'b000010, ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100, ORI = 6'b001101;
  localparam logic [5:0] SLTI = 6'b001010, DADDI = 6'b011000;
  localparam logic [5:0] BAD = 6'b111111;

  // {pcwrite,branch,iord,memwrite,irwrite,regdst,memtoreg,regwrite,
  //  alusrca,alusrcb,pcsrc,aluop,illegal}
  logic [16:0] dut_out;
  assign dut_out = {pcwrite, branch, iord, memwrite, irwrite, regdst,
                    memtoreg, regwrite, alusrca, alusrcb, pcsrc,
                    aluop, illegal};

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [16:0] out;
  } vec_t;

  localparam logic [16:0] F1   = 17'b1_0_0_0_1_0_0_0_0_01_00_000_0;
  localparam logic [16:0] F0   = 17'b0_0_0_0_0_0_0_0_0_01_00_000_0;
  localparam logic [16:0] DEC  = 17'b0_0_0_0_0_0_0_0_0_11_00_000_0;
  localparam logic [16:0] MA   = 17'b0_0_0_0_0_0_0_0_1_10_00_000_0;
  localparam logic [16:0] MR   = 17'b0_0_1_0_0_0_0_0_0_00_00_000_0;
  localparam logic [16:0] MWB  = 17'b0_0_0_0_0_0_1_1_0_00_00_000_0;
  localparam logic [16:0] MWR  = 17'b0_0_1_1_0_0_0_0_0_00_00_000_0;
  localparam logic [16:0] REX  = 17'b0_0_0_0_0_0_0_0_1_00_00_010_0;
  localparam logic [16:0] RWB  = 17'b0_0_0_0_0_1_0_1_0_00_00_000_0;
  localparam logic [16:0] BEX  = 17'b0_1_0_0_0_0_0_0_1_00_01_001_0;
  localparam logic [16:0] JX   = 17'b1_0_0_0_0_0_0_0_0_00_10_000_0;
  localparam logic [16:0] IXD  = 17'b0_0_0_0_0_0_0_0_1_10_00_110_0;
  localparam logic [16:0] IXA  = 17'b0_0_0_0_0_0_0_0_1_10_00_011_0;
  localparam logic [16:0] IWB  = 17'b0_0_0_0_0_0_0_1_0_00_00_000_0;

  // Reference model: each fetched instruction expands into its list of
  // post-fetch states; 3 and 5 (memory waits) hold while memready is low.
  typedef int iq_t[$];
  int  cur;
  iq_t plan_q;

  function automatic iq_t plan(input logic [5:0] o);
    case (o)
      LW:    return '{1, 2, 3, 4};
      SW:    return '{1, 2, 5};
      RT:    return '{1, 6, 7};
      BEQ:   return '{1, 8};
      J:     return '{1, 11};
      ADDI, ANDI, ORI, SLTI, DADDI: return '{1, 9, 10};
`ifdef MIPSCTL_ILLEGAL_TRAP_EN
      default: return '{1, 12};
`else
      default: return '{1};
`endif
    endcase
  endfunction

  function automatic logic [16:0] exp_out(input int s, input logic [5:0] o,
                                          input logic mr);
    logic pw, br, io, mw, iw, rd, mt, rw, sa, il;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    {pw, br, io, mw, iw, rd, mt, rw, sa, il} = '0;
    sb = 2'd0; ps = 2'd0; ao = 3'd0;
    if (s == 0) begin sb = 2'd1; pw = mr; iw = mr; end
    if (s == 1) sb = 2'd3;
    if (s == 2) begin sa = 1; sb = 2'd2; end
    if (s == 3) io = 1;
    if (s == 4) begin mt = 1; rw = 1; end
    if (s == 5) begin io = 1; mw = 1; end
    if (s == 6) begin sa = 1; ao = 3'd2; end
    if (s == 7) begin rd = 1; rw = 1; end
    if (s == 8) begin sa = 1; ao = 3'd1; ps = 2'd1; br = 1; end
    if (s == 9) begin
      sa = 1; sb = 2'd2;
      ao = (o == ANDI) ? 3'd3 : (o == ORI) ? 3'd4 :
           (o == SLTI) ? 3'd5 : (o == DADDI) ? 3'd6 : 3'd0;
    end
    if (s == 10) rw = 1;
    if (s == 11) begin pw = 1; ps = 2'd2; end
    if (s == 12) il = 1;
    return {pw, br, io, mw, iw, rd, mt, rw, sa, sb, ps, ao, il};
  endfunction

  task automatic model_edge(input logic [5:0] o, input logic mr);
    if (cur == 0) begin
      if (mr) begin
        plan_q = plan(o);
        cur = plan_q.pop_front();
      end
    end else if ((cur == 3 || cur == 5) && !mr) begin
    end else if (cur == 12) begin
    end else if (plan_q.size() > 0) begin
      cur = plan_q.pop_front();
    end else begin
      cur = 0;
    end
  endtask

  task automatic cycle(input logic [5:0] o, input logic mr);
    op = o;
    memready = mr;
    @(negedge clk);
    chk("state", 32'(state), 32'(cur));
    chk("outputs", 32'(dut_out), 32'(exp_out(cur, o, mr)));
    model_edge(o, mr);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cur = 0;
    plan_q.delete();
  endtask

  vec_t tbl[$];
  logic [5:0] rops[$];
  logic [5:0] rop;

  initial begin
    reset = 1'b1;
    op = RT;
    memready = 1'b0;
    cur = 0;
    #2;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_out", 32'(dut_out), 32'(F0));
    do_reset();

    tbl.push_back('{LW, 1, 0, F1});   tbl.push_back('{LW, 1, 1, DEC});
    tbl.push_back('{LW, 1, 2, MA});   tbl.push_back('{LW, 1, 3, MR});
    tbl.push_back('{LW, 1, 4, MWB});
    tbl.push_back('{RT, 0, 0, F0});   tbl.push_back('{RT, 1, 0, F1});
    tbl.push_back('{RT, 1, 1, DEC});  tbl.push_back('{RT, 1, 6, REX});
    tbl.push_back('{RT, 1, 7, RWB});
    tbl.push_back('{BEQ, 1, 0, F1});  tbl.push_back('{BEQ, 1, 1, DEC});
    tbl.push_back('{BEQ, 1, 8, BEX});
    tbl.push_back('{J, 1, 0, F1});    tbl.push_back('{J, 1, 1, DEC});
    tbl.push_back('{J, 1, 11, JX});
    tbl.push_back('{DADDI, 1, 0, F1}); tbl.push_back('{DADDI, 1, 1, DEC});
    tbl.push_back('{DADDI, 1, 9, IXD}); tbl.push_back('{DADDI, 1, 10, IWB});
    tbl.push_back('{ANDI, 1, 0, F1}); tbl.push_back('{ANDI, 1, 1, DEC});
    tbl.push_back('{ANDI, 1, 9, IXA}); tbl.push_back('{ANDI, 1, 10, IWB});
    tbl.push_back('{LW, 1, 0, F1});   tbl.push_back('{LW, 1, 1, DEC});
    tbl.push_back('{LW, 1, 2, MA});   tbl.push_back('{LW, 0, 3, MR});
    tbl.push_back('{LW, 1, 3, MR});   tbl.push_back('{LW, 1, 4, MWB});
    tbl.push_back('{SW, 1, 0, F1});   tbl.push_back('{SW, 1, 1, DEC});
    tbl.push_back('{SW, 1, 2, MA});   tbl.push_back('{SW, 1, 5, MWR});
    tbl.push_back('{RT, 0, 0, F0});

    foreach (tbl[i]) begin
      op = tbl[i].op;
      memready = tbl[i].mr;
      @(negedge clk);
      chk($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("tbl%0d_out", i), 32'(dut_out), 32'(tbl[i].out));
      @(posedge clk);
      #1;
    end

    // Asynchronous reset while sitting in RTYPEEX
    do_reset();
    cycle(RT, 1); cycle(RT, 1);
    chk("pre_reset_state", 32'(state), 32'd6);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_state", 32'(state), 32'd0);
    chk("async_reset_alusrcb", 32'(alusrcb), 32'd1);
    chk("async_reset_pc_ir", 32'({pcwrite, irwrite}), 32'd3);
    reset = 1'b0;
    cur = 0;
    plan_q.delete();
    cycle(RT, 1);
    chk("post_reset_decode", 32'(state), 32'd1);

    // SW with two wait cycles in MEMWR
    do_reset();
    cycle(SW, 1); cycle(SW, 1); cycle(SW, 1);
    for (int k = 0; k < 3; k++) begin
      op = SW;
      memready = (k == 2);
      @(negedge clk);
      chk("sw_wait_state", 32'(state), 32'd5);
      chk("sw_wait_memwrite", 32'(memwrite), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("sw_done", 32'(state), 32'd0);

    // Unknown opcode
    do_reset();
    cycle(BAD, 1); cycle(BAD, 1);
`ifdef MIPSCTL_ILLEGAL_TRAP_EN
    for (int k = 0; k < 10; k++) begin
      cycle(BAD, 1);
      chk("trap_hold", 32'({state, illegal}), 32'({4'd12, 1'b1}));
    end
`else
    chk("nop_back", 32'({state, illegal}), 32'({4'd0, 1'b0}));
`endif

    // Random instruction streams
    do_reset();
    rops = '{LW, SW, RT, BEQ, J, ADDI, ANDI, ORI, SLTI, DADDI};
`ifndef MIPSCTL_ILLEGAL_TRAP_EN
    rops.push_back(BAD);
    rops.push_back(6'b000001);
`endif
    rop = RT;
    for (int n = 0; n < 3000; n++) begin
      if (cur == 0) rop = rops[$urandom_range(0, rops.size() - 1)];
      cycle(rop, $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
